// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle and/xor/add/sub/sll/srai plus an iterative shift-add multiply,
// with valid/ready handshakes on both sides so the multiply can stall upstream.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SRAI = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    shamt;
  logic             accept;

  assign shamt      = data2_i[SW-1:0];
  assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state == MUL);

  always_comb begin
    result = '0;
    case (ALUCtrl_i)
      OP_AND:  result = data1_i & data2_i;
      OP_XOR:  result = data1_i ^ data2_i;
      OP_ADD:  result = data1_i + data2_i;
      OP_SUB:  result = data1_i - data2_i;
      OP_SLL:  result = data1_i << shamt;
      OP_SRAI: result = $unsigned($signed(data1_i) >>> shamt);
      default: result = '0;
    endcase
  end

  // Multiply runs WIDTH shift-add steps, then one drain edge publishes acc,
  // giving a fixed WIDTH+1 edge latency from the accepting edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand       <= data1_i;
              mplier      <= data2_i;
              acc         <= '0;
              cnt         <= '0;
              out_valid_o <= 1'b0;
              state       <= MUL;
            end else begin
              data_o      <= result;
              out_valid_o <= 1'b1;
            end
          end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
          end
        end
        MUL: begin
          if (cnt == LAST) begin
            data_o      <= acc;
            out_valid_o <= 1'b1;
            state       <= IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
